// File: rtl/sp_tc_pkg.sv
// Shared sparse tensor-core constants and arithmetic helpers.
// Used by the thread-group pipe and its lane datapath.
package sp_tc_pkg;

    localparam int DATA_W = 8;
    localparam int WPG    = 4;
    localparam int APG    = 8;
    localparam int IDX_W  = 2;
    localparam int PROD_W = 2 * DATA_W;
    localparam int DOT_W  = PROD_W + 2;

    // Add two signed values and clamp the sum into a w-bit signed range.
    function automatic logic signed [63:0] sat_add(
        input logic signed [63:0] a,
        input logic signed [63:0] b,
        input int                 w
    );
        logic signed [63:0] s;
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        s  = a + b;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        if (s > hi) begin
            return hi;
        end
        if (s < lo) begin
            return lo;
        end
        return s;
    endfunction

endpackage

// File: rtl/sp_threadgroup_pipe_if.sv
// Beat-in / tile-out bundle of the thread-group pipe.
// Master drives beats and out_ready; slave is the pipe.
interface sp_threadgroup_pipe_if #(
    parameter int NUM_W = 2,
    parameter int NUM_A = 2,
    parameter int ACC_W = 16
);
    localparam int NL = NUM_W * NUM_A;

    logic                  in_valid;
    logic                  in_ready;
    logic                  in_last;
    logic                  in_sparse;
    logic [NUM_W*32-1:0]   weight_groups;
    logic [NUM_W*8-1:0]    weight_idx;
    logic [NUM_A*64-1:0]   activation_groups;
    logic [NL*ACC_W-1:0]   psum_in;
    logic                  out_valid;
    logic                  out_ready;
    logic [NL*ACC_W-1:0]   result;
    logic [NL-1:0]         sat_flag;

    modport master (
        output in_valid, in_last, in_sparse, weight_groups,
        output weight_idx, activation_groups, psum_in, out_ready,
        input  in_ready, out_valid, result, sat_flag
    );

    modport slave (
        input  in_valid, in_last, in_sparse, weight_groups,
        input  weight_idx, activation_groups, psum_in, out_ready,
        output in_ready, out_valid, result, sat_flag
    );

endinterface

// File: rtl/sp_fedp_lane.sv
// One lane: operand select and four int8 products (S1 register),
// then an unregistered adder tree feeding the accumulate stage.
module sp_fedp_lane
    import sp_tc_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic                    sparse,
    input  logic [WPG*DATA_W-1:0]   w,
    input  logic [WPG*IDX_W-1:0]    idx,
    input  logic [APG*DATA_W-1:0]   act,
    output logic signed [DOT_W-1:0] dot
);

    logic signed [PROD_W-1:0] prod_d [WPG];
    logic signed [PROD_W-1:0] prod_q [WPG];

    // Pick each weight's activation (2:4 index or identity) and multiply.
    always_comb begin
        logic [2:0]               sel;
        logic signed [DATA_W-1:0] wk;
        logic signed [DATA_W-1:0] ak;
        for (int k = 0; k < WPG; k++) begin
            if (sparse) begin
                sel = 3'((k / 2) * 4) + {1'b0, idx[IDX_W*k +: IDX_W]};
            end else begin
                sel = 3'(k);
            end
            wk        = w[DATA_W*k +: DATA_W];
            ak        = act[DATA_W*sel +: DATA_W];
            prod_d[k] = wk * ak;
        end
    end

    // S1 product register, held while the pipe is stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < WPG; k++) begin
                prod_q[k] <= '0;
            end
        end else if (en) begin
            prod_q <= prod_d;
        end
    end

    // Full-precision sum of the four registered products.
    always_comb begin
        dot = '0;
        for (int k = 0; k < WPG; k++) begin
            dot = dot + {{(DOT_W-PROD_W){prod_q[k][PROD_W-1]}}, prod_q[k]};
        end
    end

endmodule

// File: rtl/sp_threadgroup_pipe.sv
// Thread-group sparse dot-product pipe: NL lanes accumulate
// per-beat dot products over a tile and emit one result per tile.
module sp_threadgroup_pipe
    import sp_tc_pkg::*;
#(
    parameter int NUM_W = 2,
    parameter int NUM_A = 2,
    parameter int ACC_W = 16,
    parameter int SAT   = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    sp_threadgroup_pipe_if.slave  bus
);

    localparam int NL = NUM_W * NUM_A;

    logic                 advance;
    logic                 accept;

    logic                 s1_valid_d, s1_valid_q;
    logic                 s1_last_d, s1_last_q;
    logic [NL*ACC_W-1:0]  s1_psum_d, s1_psum_q;
    logic                 s2_valid_d, s2_valid_q;
    logic                 s2_last_d, s2_last_q;
    logic                 first_d, first_q;
    logic                 out_valid_d, out_valid_q;
    logic [NL*ACC_W-1:0]  result_d, result_q;
    logic [NL-1:0]        sat_flag_d, sat_flag_q;
    logic [NL-1:0]        sticky_d, sticky_q;
    logic [ACC_W-1:0]     acc_d [NL];
    logic [ACC_W-1:0]     acc_q [NL];
    logic [ACC_W-1:0]     sum_w [NL];
    logic                 ovf_w [NL];

    assign advance       = !(out_valid_q && !bus.out_ready);
    assign accept        = bus.in_valid && advance;
    assign bus.in_ready  = advance;
    assign bus.out_valid = out_valid_q;
    assign bus.result    = result_q;
    assign bus.sat_flag  = sat_flag_q;

    genvar d;
    for (d = 0; d < NL; d++) begin : g_lane
        localparam int WI = d / NUM_A;
        localparam int AI = d % NUM_A;

        logic signed [DOT_W-1:0] dot;

        sp_fedp_lane u_lane (
            .clk    (clk),
            .rst    (rst),
            .en     (advance),
            .sparse (bus.in_sparse),
            .w      (bus.weight_groups[32*WI +: 32]),
            .idx    (bus.weight_idx[8*WI +: 8]),
            .act    (bus.activation_groups[64*AI +: 64]),
            .dot    (dot)
        );

        // Next accumulator value: psum seeds the first beat of a tile.
        always_comb begin
            logic [ACC_W-1:0]   base_acc;
            logic signed [63:0] base;
            logic signed [63:0] addend;
            logic signed [63:0] raw;
            logic signed [63:0] clamped;
            base_acc = first_q ? s1_psum_q[ACC_W*d +: ACC_W] : acc_q[d];
            base     = {{(64-ACC_W){base_acc[ACC_W-1]}}, base_acc};
            addend   = {{(64-DOT_W){dot[DOT_W-1]}}, dot};
            raw      = base + addend;
            clamped  = sat_add(base, addend, ACC_W);
            if (SAT != 0) begin
                sum_w[d] = clamped[ACC_W-1:0];
                ovf_w[d] = (clamped != raw);
            end else begin
                sum_w[d] = raw[ACC_W-1:0];
                ovf_w[d] = 1'b0;
            end
        end
    end

    // Pipeline advance: S1 capture, S2 accumulate, tile result load.
    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_last_d   = s1_last_q;
        s1_psum_d   = s1_psum_q;
        s2_valid_d  = s2_valid_q;
        s2_last_d   = s2_last_q;
        first_d     = first_q;
        out_valid_d = out_valid_q;
        result_d    = result_q;
        sat_flag_d  = sat_flag_q;
        sticky_d    = sticky_q;
        acc_d       = acc_q;
        if (advance) begin
            s1_valid_d  = accept;
            s1_last_d   = bus.in_last;
            s1_psum_d   = bus.psum_in;
            s2_valid_d  = s1_valid_q;
            s2_last_d   = s1_last_q;
            out_valid_d = s2_valid_q && s2_last_q;
            if (s1_valid_q) begin
                first_d = s1_last_q;
                for (int i = 0; i < NL; i++) begin
                    acc_d[i]    = sum_w[i];
                    sticky_d[i] = ovf_w[i] | (!first_q && sticky_q[i]);
                end
            end
            if (s2_valid_q && s2_last_q) begin
                for (int i = 0; i < NL; i++) begin
                    result_d[ACC_W*i +: ACC_W] = acc_q[i];
                end
                sat_flag_d = sticky_q;
            end
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_last_q   <= 1'b0;
            s1_psum_q   <= '0;
            s2_valid_q  <= 1'b0;
            s2_last_q   <= 1'b0;
            first_q     <= 1'b1;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            sat_flag_q  <= '0;
            sticky_q    <= '0;
            for (int i = 0; i < NL; i++) begin
                acc_q[i] <= '0;
            end
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_last_q   <= s1_last_d;
            s1_psum_q   <= s1_psum_d;
            s2_valid_q  <= s2_valid_d;
            s2_last_q   <= s2_last_d;
            first_q     <= first_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            sat_flag_q  <= sat_flag_d;
            sticky_q    <= sticky_d;
            acc_q       <= acc_d;
        end
    end

endmodule

// File: tb/tb_sp_threadgroup_pipe.sv
// Bench for sp_threadgroup_pipe: saturating and wrapping instances
// share one stimulus stream and are scored against a tile model.
module tb_sp_threadgroup_pipe;

    localparam int NW = 2;
    localparam int NA = 2;
    localparam int AW = 16;
    localparam int NL = NW * NA;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    sp_threadgroup_pipe_if #(.NUM_W(NW), .NUM_A(NA), .ACC_W(AW)) ifs ();
    sp_threadgroup_pipe_if #(.NUM_W(NW), .NUM_A(NA), .ACC_W(AW)) ifw ();

    sp_threadgroup_pipe #(.NUM_W(NW), .NUM_A(NA), .ACC_W(AW), .SAT(1)) u_dut_sat (
        .clk (clk),
        .rst (rst),
        .bus (ifs)
    );

    sp_threadgroup_pipe #(.NUM_W(NW), .NUM_A(NA), .ACC_W(AW), .SAT(0)) u_dut_wrap (
        .clk (clk),
        .rst (rst),
        .bus (ifw)
    );

    assign ifw.in_valid          = ifs.in_valid;
    assign ifw.in_last           = ifs.in_last;
    assign ifw.in_sparse         = ifs.in_sparse;
    assign ifw.weight_groups     = ifs.weight_groups;
    assign ifw.weight_idx        = ifs.weight_idx;
    assign ifw.activation_groups = ifs.activation_groups;
    assign ifw.psum_in           = ifs.psum_in;
    assign ifw.out_ready         = ifs.out_ready;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    typedef struct {
        logic [NL*AW-1:0] res_s;
        logic [NL*AW-1:0] res_w;
        logic [NL-1:0]    flg_s;
    } exp_t;

    exp_t        sb [$];
    exp_t        e;
    int          m_acc_s [NL];
    int          m_acc_w [NL];
    logic [NL-1:0] m_flg;
    bit          m_first = 1'b1;
    int          n_out = 0;
    bit          rnd_on = 1'b0;

    function automatic int dot_ref(input int dl, input logic sp,
                                   input logic [NW*32-1:0] w,
                                   input logic [NW*8-1:0] ix,
                                   input logic [NA*64-1:0] ac);
        int wg, ag, s, sel;
        logic [31:0] wv;
        logic [7:0]  iv;
        logic [63:0] av;
        wg = dl / NA;
        ag = dl % NA;
        wv = w[32*wg +: 32];
        iv = ix[8*wg +: 8];
        av = ac[64*ag +: 64];
        s  = 0;
        for (int k = 0; k < 4; k++) begin
            sel = sp ? (k / 2) * 4 + int'(iv[2*k +: 2]) : k;
            s += int'($signed(wv[8*k +: 8])) * int'($signed(av[8*sel +: 8]));
        end
        return s;
    endfunction

    // Scoreboard model and output comparison, sampled mid-cycle.
    always @(negedge clk) begin
        if (rst) begin
            m_first = 1'b1;
        end else begin
            if (ifs.out_valid && ifs.out_ready) begin
                n_out++;
                chk("sb_nonempty", sb.size() != 0, 1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    chk("res_sat", ifs.result, e.res_s);
                    chk("flag_sat", ifs.sat_flag, e.flg_s);
                    chk("res_wrap", ifw.result, e.res_w);
                    chk("flag_wrap", ifw.sat_flag, 0);
                end
            end
            if (ifs.in_valid && ifs.in_ready) begin
                for (int dl = 0; dl < NL; dl++) begin
                    int p, dt, vs, vw;
                    bit ovf;
                    p  = int'($signed(ifs.psum_in[AW*dl +: AW]));
                    dt = dot_ref(dl, ifs.in_sparse, ifs.weight_groups,
                                 ifs.weight_idx, ifs.activation_groups);
                    vs  = (m_first ? p : m_acc_s[dl]) + dt;
                    ovf = 1'b0;
                    if (vs > 32767) begin
                        vs  = 32767;
                        ovf = 1'b1;
                    end else if (vs < -32768) begin
                        vs  = -32768;
                        ovf = 1'b1;
                    end
                    m_acc_s[dl] = vs;
                    m_flg[dl]   = m_first ? ovf : (m_flg[dl] | ovf);
                    vw = (m_first ? p : m_acc_w[dl]) + dt;
                    m_acc_w[dl] = int'(shortint'(vw));
                    e.res_s[AW*dl +: AW] = 16'(m_acc_s[dl]);
                    e.res_w[AW*dl +: AW] = 16'(m_acc_w[dl]);
                end
                e.flg_s = m_flg;
                if (ifs.in_last) begin
                    sb.push_back(e);
                end
                m_first = ifs.in_last;
            end
        end
    end

    function automatic logic [NW*32-1:0] wfill(input int v);
        logic [NW*32-1:0] r;
        for (int i = 0; i < NW * 4; i++) begin
            r[8*i +: 8] = 8'(v);
        end
        return r;
    endfunction

    function automatic logic [NA*64-1:0] afill(input logic [63:0] g);
        logic [NA*64-1:0] r;
        for (int i = 0; i < NA; i++) begin
            r[64*i +: 64] = g;
        end
        return r;
    endfunction

    function automatic logic [NL*AW-1:0] psfill(input int v);
        logic [NL*AW-1:0] r;
        for (int i = 0; i < NL; i++) begin
            r[AW*i +: AW] = 16'(v);
        end
        return r;
    endfunction

    task automatic send(input logic sp, input logic last,
                        input logic [NW*32-1:0] w, input logic [NW*8-1:0] ix,
                        input logic [NA*64-1:0] ac, input logic [NL*AW-1:0] ps);
        int budget;
        budget                = 200;
        ifs.in_valid          = 1'b1;
        ifs.in_sparse         = sp;
        ifs.in_last           = last;
        ifs.weight_groups     = w;
        ifs.weight_idx        = ix;
        ifs.activation_groups = ac;
        ifs.psum_in           = ps;
        forever begin
            @(negedge clk);
            if (ifs.in_ready || budget == 0) break;
            budget--;
        end
        chk("accept_in_budget", ifs.in_ready, 1);
        @(posedge clk);
        #1;
        ifs.in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_valid();
        int b;
        b = 30;
        while (!ifs.out_valid && b > 0) begin
            @(posedge clk);
            #1;
            b--;
        end
        chk("out_valid_seen", ifs.out_valid, 1);
    endtask

    task automatic drain();
        int b;
        b = 300;
        while (sb.size() != 0 && b > 0) begin
            @(posedge clk);
            #1;
            b--;
        end
        chk("drain_empty", sb.size(), 0);
    endtask

    localparam logic [63:0] A18  = 64'h0807060504030201;
    localparam logic [63:0] A5   = 64'h0000000002010101;
    localparam logic [63:0] A7   = 64'h0000000000040201;
    localparam logic [63:0] A127 = 64'h7f7f7f7f7f7f7f7f;

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        logic [NL*AW-1:0] snap;
        int n0;
        rst                   = 1'b1;
        ifs.in_valid          = 1'b0;
        ifs.in_last           = 1'b0;
        ifs.in_sparse         = 1'b0;
        ifs.weight_groups     = '0;
        ifs.weight_idx        = '0;
        ifs.activation_groups = '0;
        ifs.psum_in           = '0;
        ifs.out_ready         = 1'b1;
        idle(3);
        chk("rst_out_valid", ifs.out_valid, 0);
        chk("rst_result", ifs.result, 0);
        chk("rst_sat_flag", ifs.sat_flag, 0);
        rst = 1'b0;
        idle(1);
        chk("in_ready_after_rst", ifs.in_ready, 1);

        // dense single beat, latency of two edges
        send(1'b0, 1'b1, wfill(1), '0, afill(A18), psfill(10));
        chk("lat_edge0", ifs.out_valid, 0);
        idle(1);
        chk("lat_edge1", ifs.out_valid, 0);
        idle(1);
        chk("lat_edge2", ifs.out_valid, 1);
        chk("dense_res", ifs.result, {NL{16'd20}});
        idle(2);

        // sparse select
        send(1'b1, 1'b1, wfill(1), {NW{8'b11_10_01_00}}, afill(A18), psfill(0));
        wait_valid();
        chk("sparse_res", ifs.result, {NL{16'd18}});
        idle(2);

        // three-beat tile, one handshake
        n0 = n_out;
        send(1'b0, 1'b0, wfill(1), '0, afill(A5), psfill(-3));
        send(1'b0, 1'b0, wfill(1), '0, afill(A5), psfill(-3));
        send(1'b0, 1'b1, wfill(1), '0, afill(A5), psfill(-3));
        wait_valid();
        chk("tile3_res", ifs.result, {NL{16'd12}});
        idle(4);
        chk("tile3_handshakes", n_out - n0, 1);
        chk("tile3_valid_low", ifs.out_valid, 0);

        // saturation vs wrap
        send(1'b0, 1'b1, wfill(127), '0, afill(A127), psfill(32760));
        wait_valid();
        chk("sat_pos_res", ifs.result, {NL{16'h7fff}});
        chk("sat_pos_flag", ifs.sat_flag, {NL{1'b1}});
        chk("wrap_pos_res", ifw.result, {NL{16'd31740}});
        chk("wrap_pos_flag", ifw.sat_flag, 0);
        idle(2);
        send(1'b0, 1'b1, wfill(-128), '0, afill(A127), psfill(-32760));
        wait_valid();
        chk("sat_neg_res", ifs.result, {NL{16'h8000}});
        chk("wrap_neg_res", ifw.result, {NL{16'h8208}});
        idle(2);
        send(1'b0, 1'b0, wfill(127), '0, afill(A127), psfill(32760));
        send(1'b0, 1'b1, wfill(-128), '0, afill(A127), psfill(0));
        wait_valid();
        chk("sticky_flag", ifs.sat_flag, {NL{1'b1}});
        idle(2);

        // backpressure with beats in flight
        ifs.out_ready = 1'b0;
        fork
            begin
                send(1'b0, 1'b1, wfill(1), '0, afill(A18), psfill(0));
                send(1'b0, 1'b0, wfill(2), '0, afill(A18), psfill(5));
                send(1'b0, 1'b1, wfill(1), '0, afill(A7), psfill(5));
                send(1'b1, 1'b1, wfill(3), {NW{8'b01_10_11_00}}, afill(A18), psfill(-7));
            end
            begin
                wait_valid();
                snap = ifs.result;
                chk("bp_first", snap, {NL{16'd10}});
                repeat (5) begin
                    idle(1);
                    chk("bp_in_ready", ifs.in_ready, 0);
                    chk("bp_hold", ifs.result, snap);
                end
                ifs.out_ready = 1'b1;
            end
        join
        drain();

        // reset in the middle of a tile
        send(1'b0, 1'b0, wfill(1), '0, afill(A18), psfill(100));
        send(1'b0, 1'b0, wfill(1), '0, afill(A18), psfill(100));
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        send(1'b0, 1'b1, wfill(1), '0, afill(A7), psfill(0));
        wait_valid();
        chk("post_rst_res", ifs.result, {NL{16'd7}});
        idle(2);

        // random tiles under random backpressure
        rnd_on = 1'b1;
        fork
            begin
                for (int t = 0; t < 40; t++) begin
                    int len;
                    logic sp;
                    len = $urandom_range(1, 3);
                    sp  = 1'($urandom_range(0, 1));
                    for (int b = 0; b < len; b++) begin
                        logic [NW*32-1:0] w;
                        logic [NA*64-1:0] ac;
                        logic [NL*AW-1:0] ps;
                        w  = {$urandom(), $urandom()};
                        ac = {$urandom(), $urandom(), $urandom(), $urandom()};
                        for (int i = 0; i < NL; i++) begin
                            ps[AW*i +: AW] = 16'($urandom_range(0, 4000) - 2000);
                        end
                        send(sp, b == len - 1, w, 16'($urandom()), ac, ps);
                        if ($urandom_range(0, 3) == 0) idle(1);
                    end
                end
                rnd_on = 1'b0;
            end
            begin
                while (rnd_on) begin
                    @(posedge clk);
                    #1;
                    ifs.out_ready = 1'($urandom_range(0, 1));
                end
                ifs.out_ready = 1'b1;
            end
        join
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
